// File: rtl/mem_sys_control_unit.sv
// mem_sys_control_unit
//   Multi-cycle fetch / decode / execute sequencer for the memory_system
//   datapath. Every control strobe is registered: on each clock edge the
//   strobe set for the state being entered is computed and loaded together
//   with the state. Two outputs cannot be known one cycle ahead, so they are
//   decoded from the current state instead:
//     - illegal, which depends on the IR contents during DEC. The IR only
//       loads at the end of F2.
//     - the JZ PC write, which depends on the live Z flag during EX_JZ.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               leaves IDLE when 1. Only sampled in IDLE.
//   instruction[4:0]    IR contents fed back from the datapath
//   C, N, P, Z          ALU flags. Only Z is used, by JZ.
//   ir_sclr, mar_sclr   synchronous clears of IR / MAR
//   enaf                flag register update enable
//   selop[2:0]          ALU operation
//   shamt[1:0]          shift amount
//   bank_wr_en          register bank write enable
//   busB_addr[2:0]      register bank read address
//   busC_addr[2:0]      register bank write address
//   ir_en, mar_en       IR / MAR load enables
//   mdr_en              MDR load enable
//   wr_rdn              1 = memory write, 0 = memory read
//   mdr_alu_n           busC source: 1 = MDR, 0 = ALU
//   busy                high in every state except IDLE and HALT
//   halted              high in HALT
//   illegal             one-cycle pulse in DEC on an undefined opcode
//   state_dbg[3:0]      current state encoding
module mem_sys_control_unit #(
    parameter logic [2:0] REG_PC   = 3'b000,
    parameter logic [2:0] REG_DPTR = 3'b001,
    parameter logic [2:0] REG_A    = 3'b010,
    parameter logic [2:0] REG_ACC  = 3'b111,
    parameter logic [2:0] OP_PASSB = 3'b000,
    parameter logic [2:0] OP_INCB  = 3'b001,
    parameter logic [2:0] OP_SHIFT = 3'b110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic       busy,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        F0     = 4'd2,
        F1     = 4'd3,
        F2     = 4'd4,
        DEC    = 4'd5,
        EX_ALU = 4'd6,
        EX_SH  = 4'd7,
        L0     = 4'd8,
        L1     = 4'd9,
        L2     = 4'd10,
        S0     = 4'd11,
        S1     = 4'd12,
        S2     = 4'd13,
        EX_JZ  = 4'd14,
        HALT   = 4'd15
    } state_t;

    typedef struct packed {
        logic       ir_sclr;
        logic       mar_sclr;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic [2:0] busB_addr;
        logic [2:0] busC_addr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       wr_rdn;
        logic       mdr_alu_n;
        logic       busy;
        logic       halted;
    } ctrl_t;

    state_t state, state_nxt;
    ctrl_t  ctrl;
    logic   jz_take;

    // C, N and P belong to the flag bus but no instruction branches on them.
    logic unused_flags;
    assign unused_flags = ^{C, N, P};

    function automatic logic is_legal(input logic [4:0] ins);
        logic ok;
        casez (ins)
            5'b00000, 5'b01???, 5'b100??,
            5'b11000, 5'b11001, 5'b11010, 5'b11111: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic state_t next_of(input state_t s, input logic go,
                                       input logic [4:0] ins);
        state_t n;
        case (s)
            IDLE:   n = go ? INIT : IDLE;
            INIT:   n = F0;
            F0:     n = F1;
            F1:     n = F2;
            F2:     n = DEC;
            DEC: begin
                casez (ins)
                    5'b01???: n = EX_ALU;
                    5'b100??: n = EX_SH;
                    5'b11000: n = L0;
                    5'b11001: n = S0;
                    5'b11010: n = EX_JZ;
                    5'b11111: n = HALT;
                    default:  n = F0;   // NOP, and undefined opcodes
                endcase
            end
            L0:     n = L1;
            L1:     n = L2;
            S0:     n = S1;
            S1:     n = S2;
            HALT:   n = HALT;           // only rst leaves HALT
            default: n = F0;            // EX_ALU, EX_SH, L2, S2, EX_JZ
        endcase
        return n;
    endfunction

    // Strobe set for state s. EX_ALU / EX_SH take their op fields from the
    // instruction seen in DEC, which is the cycle this value is registered.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [4:0] ins);
        ctrl_t c;
        c        = '0;
        c.busy   = (s != IDLE) && (s != HALT);
        c.halted = (s == HALT);
        case (s)
            INIT: begin
                c.ir_sclr  = 1'b1;
                c.mar_sclr = 1'b1;
            end
            F0, L0, S0: begin
                c.busB_addr = (s == F0) ? REG_PC : REG_DPTR;
                c.selop     = OP_PASSB;
                c.mar_en    = 1'b1;
            end
            F1, L1: begin
                c.wr_rdn    = 1'b0;
                c.mdr_en    = 1'b1;
                c.mdr_alu_n = 1'b1;
            end
            F2: begin
                c.ir_en      = 1'b1;
                c.busB_addr  = REG_PC;
                c.busC_addr  = REG_PC;
                c.selop      = OP_INCB;
                c.bank_wr_en = 1'b1;
            end
            EX_ALU: begin
                c.busB_addr  = REG_A;
                c.busC_addr  = REG_ACC;
                c.selop      = ins[2:0];
                c.bank_wr_en = 1'b1;
                c.enaf       = 1'b1;
            end
            EX_SH: begin
                c.busB_addr  = REG_ACC;
                c.busC_addr  = REG_ACC;
                c.selop      = OP_SHIFT;
                c.shamt      = ins[1:0];
                c.bank_wr_en = 1'b1;
                c.enaf       = 1'b1;
            end
            L2: begin
                c.busC_addr  = REG_A;
                c.mdr_alu_n  = 1'b1;
                c.bank_wr_en = 1'b1;
            end
            S1: begin
                c.busB_addr = REG_ACC;
                c.selop     = OP_PASSB;
                c.mdr_alu_n = 1'b0;
                c.mdr_en    = 1'b1;
            end
            S2: c.wr_rdn = 1'b1;
            default: ;                  // IDLE, DEC, EX_JZ, HALT: no strobes
        endcase
        return c;
    endfunction

    assign state_nxt = next_of(state, start, instruction);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctrl  <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_of(state_nxt, instruction);
        end
    end

    // JZ taken: PC <= DPTR through the ALU pass path.
    assign jz_take    = (state == EX_JZ) && Z;

    assign ir_sclr    = ctrl.ir_sclr;
    assign mar_sclr   = ctrl.mar_sclr;
    assign enaf       = ctrl.enaf;
    assign selop      = jz_take ? OP_PASSB : ctrl.selop;
    assign shamt      = ctrl.shamt;
    assign bank_wr_en = ctrl.bank_wr_en | jz_take;
    assign busB_addr  = jz_take ? REG_DPTR : ctrl.busB_addr;
    assign busC_addr  = jz_take ? REG_PC   : ctrl.busC_addr;
    assign ir_en      = ctrl.ir_en;
    assign mar_en     = ctrl.mar_en;
    assign mdr_en     = ctrl.mdr_en;
    assign wr_rdn     = ctrl.wr_rdn;
    assign mdr_alu_n  = ctrl.mdr_alu_n;
    assign busy       = ctrl.busy;
    assign halted     = ctrl.halted;
    assign illegal    = (state == DEC) && !is_legal(instruction);
    assign state_dbg  = state;

endmodule

// File: tb/tb_mem_sys_control_unit.sv
// Directed bench for mem_sys_control_unit. All outputs are packed into obs
// and compared against hand-written vectors:
//   {state[3:0], selop[2:0], shamt[1:0], busB[2:0], busC[2:0], flags[11:0]}
// flags = {ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en,
//          wr_rdn, mdr_alu_n, busy, halted, illegal}
module tb_mem_sys_control_unit;
    logic       clk, rst, start;
    logic [4:0] instruction;
    logic       C, N, P, Z;
    logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en;
    logic       wr_rdn, mdr_alu_n, busy, halted, illegal;
    logic [2:0] selop, busB_addr, busC_addr;
    logic [1:0] shamt;
    logic [3:0] state_dbg;
    int         checks = 0;
    int         failures = 0;

    mem_sys_control_unit dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction),
        .C(C), .N(N), .P(P), .Z(Z),
        .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop),
        .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
        .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .busy(busy), .halted(halted),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    logic [26:0] obs;
    assign obs = {state_dbg, selop, shamt, busB_addr, busC_addr,
                  ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en,
                  wr_rdn, mdr_alu_n, busy, halted, illegal};

    // Expected vectors for the fixed-strobe states
    localparam logic [26:0] E_IDLE = 27'd0;
    localparam logic [26:0] E_INIT = {4'd1,  3'b000, 2'b00, 3'b000, 3'b000, 12'b1100_0000_0100};
    localparam logic [26:0] E_F0   = {4'd2,  3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0100_0100};
    localparam logic [26:0] E_F1   = {4'd3,  3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0010_1100};
    localparam logic [26:0] E_F2   = {4'd4,  3'b001, 2'b00, 3'b000, 3'b000, 12'b0001_1000_0100};
    localparam logic [26:0] E_DEC  = {4'd5,  3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0000_0100};
    localparam logic [26:0] E_L0   = {4'd8,  3'b000, 2'b00, 3'b001, 3'b000, 12'b0000_0100_0100};
    localparam logic [26:0] E_L1   = {4'd9,  3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0010_1100};
    localparam logic [26:0] E_L2   = {4'd10, 3'b000, 2'b00, 3'b000, 3'b010, 12'b0001_0000_1100};
    localparam logic [26:0] E_S0   = {4'd11, 3'b000, 2'b00, 3'b001, 3'b000, 12'b0000_0100_0100};
    localparam logic [26:0] E_S1   = {4'd12, 3'b000, 2'b00, 3'b111, 3'b000, 12'b0000_0010_0100};
    localparam logic [26:0] E_S2   = {4'd13, 3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0001_0100};
    localparam logic [26:0] E_HALT = {4'd15, 3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0000_0010};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs F0 -> F1 -> F2 -> DEC for the given instruction, ending in DEC.
    task automatic fetch(input logic [4:0] ins, input string nm);
        instruction = ins;
        if (obs !== E_F0) begin failures++; $display("FAIL %s_f0 got=%h exp=%h", nm, obs, E_F0); end
        checks++;
        step();
        if (obs !== E_F1) begin failures++; $display("FAIL %s_f1 got=%h exp=%h", nm, obs, E_F1); end
        checks++;
        step();
        if (obs !== E_F2) begin failures++; $display("FAIL %s_f2 got=%h exp=%h", nm, obs, E_F2); end
        checks++;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; instruction = 5'b0; {C, N, P, Z} = 4'b0;
        repeat (3) step();
        if (obs !== E_IDLE) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs, E_IDLE); end
        checks++;
        start = 1'b0; rst = 1'b1;
        step(); step();
        if (obs !== E_IDLE) begin failures++; $display("FAIL idle_wait got=%h exp=%h", obs, E_IDLE); end
        checks++;
        start = 1'b1;
        step();
        if (obs !== E_INIT) begin failures++; $display("FAIL init got=%h exp=%h", obs, E_INIT); end
        checks++;
        step();
        start = 1'b0;   // mid-program deassert has no effect
    endtask

    task automatic test_nop();
        fetch(5'b00000, "nop");
        if (obs !== E_DEC) begin failures++; $display("FAIL nop_dec got=%h exp=%h", obs, E_DEC); end
        checks++;
        step();
        if (obs !== E_F0) begin failures++; $display("FAIL nop_ret got=%h exp=%h", obs, E_F0); end
        checks++;
    endtask

    task automatic test_alu();
        logic [26:0] e = {4'd6, 3'b010, 2'b00, 3'b010, 3'b111, 12'b0011_0000_0100};
        fetch(5'b01010, "alu");
        step();
        if (obs !== e) begin failures++; $display("FAIL alu_ex got=%h exp=%h", obs, e); end
        checks++;
        step();
    endtask

    task automatic test_shift();
        logic [26:0] e = {4'd7, 3'b110, 2'b11, 3'b111, 3'b111, 12'b0011_0000_0100};
        fetch(5'b10011, "sh");
        step();
        if (obs !== e) begin failures++; $display("FAIL sh_ex got=%h exp=%h", obs, e); end
        checks++;
        step();
    endtask

    task automatic test_load();
        fetch(5'b11000, "ld");
        step();
        if (obs !== E_L0) begin failures++; $display("FAIL ld_l0 got=%h exp=%h", obs, E_L0); end
        checks++;
        step();
        if (obs !== E_L1) begin failures++; $display("FAIL ld_l1 got=%h exp=%h", obs, E_L1); end
        checks++;
        step();
        if (obs !== E_L2) begin failures++; $display("FAIL ld_l2 got=%h exp=%h", obs, E_L2); end
        checks++;
        step();
    endtask

    task automatic test_store();
        fetch(5'b11001, "st");
        step();
        if (obs !== E_S0) begin failures++; $display("FAIL st_s0 got=%h exp=%h", obs, E_S0); end
        checks++;
        step();
        if (obs !== E_S1) begin failures++; $display("FAIL st_s1 got=%h exp=%h", obs, E_S1); end
        checks++;
        step();
        if (obs !== E_S2) begin failures++; $display("FAIL st_s2 got=%h exp=%h", obs, E_S2); end
        checks++;
        step();
        if (obs !== E_F0) begin failures++; $display("FAIL st_ret got=%h exp=%h", obs, E_F0); end
        checks++;
    endtask

    task automatic test_jz(input logic z);
        logic [26:0] e;
        e = z ? {4'd14, 3'b000, 2'b00, 3'b001, 3'b000, 12'b0001_0000_0100}
              : {4'd14, 3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0000_0100};
        Z = z;
        fetch(5'b11010, "jz");
        step();
        if (obs !== e) begin failures++; $display("FAIL jz_z%0d got=%h exp=%h", z, obs, e); end
        checks++;
        step();
        Z = 1'b0;
    endtask

    task automatic test_illegal();
        logic [26:0] e = {4'd5, 3'b000, 2'b00, 3'b000, 3'b000, 12'b0000_0000_0101};
        fetch(5'b10100, "ill");
        if (obs !== e) begin failures++; $display("FAIL ill_dec got=%h exp=%h", obs, e); end
        checks++;
        step();
        if (obs !== E_F0) begin failures++; $display("FAIL ill_ret got=%h exp=%h", obs, E_F0); end
        checks++;
    endtask

    task automatic test_reset_mid_store();
        fetch(5'b11001, "rs");
        repeat (3) step();
        if (obs !== E_S2) begin failures++; $display("FAIL rs_s2 got=%h exp=%h", obs, E_S2); end
        checks++;
        start = 1'b1;
        #2 rst = 1'b0;
        #1;
        if ({wr_rdn, state_dbg} !== 5'b0) begin failures++; $display("FAIL rs_async wr_rdn=%b state=%0d exp 0/0", wr_rdn, state_dbg); end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        step();
        if (obs !== E_INIT) begin failures++; $display("FAIL rs_init got=%h exp=%h", obs, E_INIT); end
        checks++;
        step();
        start = 1'b0;
    endtask

    task automatic test_halt();
        fetch(5'b11111, "hlt");
        step();
        for (int i = 0; i < 10; i++) begin
            if (obs !== E_HALT) begin failures++; $display("FAIL halt_%0d got=%h exp=%h", i, obs, E_HALT); end
            checks++;
            start = ~start;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_alu();
        test_shift();
        test_load();
        test_store();
        test_jz(1'b1);
        test_jz(1'b0);
        test_illegal();
        test_reset_mid_store();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_sys_control_unit.md
Name: mem_sys_control_unit

Overview: Multi-cycle control FSM that sequences the memory_system datapath through fetch, decode and execute. It drives every datapath control strobe (register bank addressing, ALU op/shift, IR/MAR/MDR enables, memory read/write). It consumes the 5-bit instruction and the C/N/P/Z flags fed back from memory_system.

Parameters:
REG_PC, 3'b000, bank address of PC
REG_DPTR, 3'b001, bank address of DPTR
REG_A, 3'b010, bank address of A
REG_ACC, 3'b111, bank address of ACC
OP_PASSB, 3'b000, selop value that passes busB to the ALU output
OP_INCB, 3'b001, selop value giving busB+1
OP_SHIFT, 3'b110, selop value that shifts busB by shamt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  level; leaving IDLE requires start=1
instruction  in  5  IR contents from memory_system
C, N, P, Z  in  1 each  ALU flags from memory_system
ir_sclr, mar_sclr  out  1 each  synchronous clear of IR / MAR
enaf  out  1  flag register update enable
selop  out  3  ALU operation
shamt  out  2  shift amount
bank_wr_en  out  1  register bank write enable
busB_addr, busC_addr  out  3 each  bank read / write address
ir_en, mar_en, mdr_en  out  1 each  IR / MAR / MDR load enables
wr_rdn  out  1  1 = memory write, 0 = read
mdr_alu_n  out  1  busC source: 1 = MDR, 0 = ALU
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
illegal  out  1  one-cycle pulse on an undefined opcode
state_dbg  out  4  current state encoding

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0.
- Moore outputs decoded from state, except JZ, which also uses Z. Any output not listed for a state is 0.
- Datapath convention: MAR loads from the ALU output. IR loads from MDR. MDR loads mem[MAR] when wr_rdn=0, or the ALU output when mdr_alu_n=0 in store states.
- IDLE(0): if start=1, go to INIT.
- INIT(1): ir_sclr=1, mar_sclr=1. Go to F0.
- F0(2): busB_addr=REG_PC, selop=OP_PASSB, mar_en=1.
- F1(3): wr_rdn=0, mdr_en=1, mdr_alu_n=1 (MDR<=mem[MAR]).
- F2(4): ir_en=1. PC<=PC+1: busB_addr=busC_addr=REG_PC, selop=OP_INCB, bank_wr_en=1.
- DEC(5): no strobes. Next state chosen from instruction:
  - 00000 NOP -> F0
  - 01sss ALU -> EX_ALU
  - 100hh SHIFT -> EX_SH
  - 11000 LOAD -> L0
  - 11001 STORE -> S0
  - 11010 JZ -> EX_JZ
  - 11111 HALT -> HALT
  - anything else -> F0, with illegal=1 during DEC.
- EX_ALU(6): ACC<=A op ACC. busB_addr=REG_A, busC_addr=REG_ACC, selop=instruction[2:0], bank_wr_en=1, enaf=1. Go to F0.
- EX_SH(7): busB_addr=busC_addr=REG_ACC, selop=OP_SHIFT, shamt=instruction[1:0], bank_wr_en=1, enaf=1. Go to F0.
- L0(8): busB_addr=REG_DPTR, selop=OP_PASSB, mar_en=1.
- L1(9): as F1.
- L2(10): busC_addr=REG_A, mdr_alu_n=1, bank_wr_en=1. Go to F0.
- S0(11): as L0.
- S1(12): busB_addr=REG_ACC, selop=OP_PASSB, mdr_alu_n=0, mdr_en=1.
- S2(13): wr_rdn=1 for exactly one cycle. Go to F0.
- EX_JZ(14): if Z=1, busB_addr=REG_DPTR, selop=OP_PASSB, busC_addr=REG_PC, bank_wr_en=1. Otherwise no strobes. Go to F0.
- HALT(15): halted=1. Exit only via rst. start is ignored.
- start is sampled only in IDLE. Deasserting start mid-program has no effect.
- Reset mid-operation aborts immediately, including mid-S2: wr_rdn drops asynchronously.
- Cycle counts, fetch through execute: NOP 4, ALU/SHIFT/JZ 5, LOAD/STORE 7.
- wr_rdn and bank_wr_en are never both 1. mar_en and ir_en are never both 1.

Test Plan:
- Reset: hold rst=0 with start=1 -> all outputs 0, state_dbg=0. Release rst -> INIT, then F0; ir_sclr=mar_sclr=1 in INIT only.
- Fetch of NOP (instruction=00000) -> state sequence 2,3,4,5,2. In state 4: ir_en=1, bank_wr_en=1, selop=001, busB_addr=busC_addr=000.
- instruction=01010 -> EX_ALU with selop=010, busB_addr=010, busC_addr=111, enaf=1, bank_wr_en=1.
- instruction=10011 -> shamt=11, selop=110. instruction=11000 -> L2 with busC_addr=010, mdr_alu_n=1.
- STORE (11001) -> single wr_rdn=1 cycle in state 13. JZ with Z=1 -> busC_addr=000, bank_wr_en=1. JZ with Z=0 -> no strobes.
- instruction=10100 -> illegal pulse of one cycle, return to F0. instruction=11111 -> halted=1 held for 10 cycles despite start toggling. rst asserted mid-S2 -> wr_rdn=0 before the next clk edge.
